// File: rtl/contador_universal.sv
// Universal event/timebase counter: programmable modulo, enable prescaler,
// up/down, synchronous load, wrap or saturate, terminal pulse, sticky overflow.
module contador_universal #(
  parameter int WIDTH    = 6,
  parameter int MAX      = (2**WIDTH)-1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] out,
  output logic             terminal,
  output logic             overflow
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE-1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             terminal_q, terminal_d;
  logic             overflow_q, overflow_d;
  logic             step;
  logic             at_bound;

  always_comb begin
    out_d      = out_q;
    pre_d      = pre_q;
    terminal_d = 1'b0;
    overflow_d = overflow_q & ~clear_flag;
    step       = 1'b0;
    at_bound   = up_down ? (out_q == MAX_V) : (out_q == '0);

    if (load) begin
      out_d = (load_value > MAX_V) ? MAX_V : load_value;
      pre_d = '0;
    end else if (enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // A step at a bound always pulses terminal and sets overflow, even when clear_flag is high
    if (step) begin
      if (at_bound) begin
        terminal_d = 1'b1;
        overflow_d = 1'b1;
        if (!sat_mode) begin
          out_d = up_down ? '0 : MAX_V;
        end
      end else begin
        out_d = up_down ? (out_q + 1'b1) : (out_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q      <= '0;
      pre_q      <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      pre_q      <= pre_d;
      terminal_q <= terminal_d;
      overflow_q <= overflow_d;
    end
  end

  assign out      = out_q;
  assign terminal = terminal_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_contador_universal.sv
// Scoreboard bench for contador_universal: instance A (4-bit, MAX=9, PRESCALE=1)
// and instance B (6-bit, MAX=63, PRESCALE=4), directed vectors with hand-computed results.
module tb_contador_universal;

  logic       clk = 1'b0;

  logic       reset_a = 1'b1, enable_a = 1'b0, up_down_a = 1'b1, load_a = 1'b0;
  logic [3:0] load_value_a = '0;
  logic       sat_mode_a = 1'b0, clear_flag_a = 1'b0;
  logic [3:0] out_a;
  logic       terminal_a, overflow_a;

  logic       reset_b = 1'b1, enable_b = 1'b0, up_down_b = 1'b1, load_b = 1'b0;
  logic [5:0] load_value_b = '0;
  logic       sat_mode_b = 1'b0, clear_flag_b = 1'b0;
  logic [5:0] out_b;
  logic       terminal_b, overflow_b;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    bit          sel;
    logic [15:0] out;
    logic        term;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  contador_universal #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .up_down(up_down_a),
    .load(load_a), .load_value(load_value_a), .sat_mode(sat_mode_a),
    .clear_flag(clear_flag_a), .out(out_a), .terminal(terminal_a), .overflow(overflow_a)
  );

  contador_universal #(.WIDTH(6), .MAX(63), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .up_down(up_down_b),
    .load(load_b), .load_value(load_value_b), .sat_mode(sat_mode_b),
    .clear_flag(clear_flag_b), .out(out_b), .terminal(terminal_b), .overflow(overflow_b)
  );

  // Drives one instance for one cycle (the other idles) and queues the result expected after the edge
  task automatic applyStimulus(input bit sel, input logic rst, input logic en, input logic ud,
                               input logic ld, input logic [15:0] lv, input logic sat,
                               input logic clr, input logic [15:0] e_out, input logic e_term,
                               input logic e_ovf, input string name);
    exp_t e;
    @(negedge clk);
    reset_a = 1'b1; enable_a = 1'b0; load_a = 1'b0; clear_flag_a = 1'b0;
    reset_b = 1'b1; enable_b = 1'b0; load_b = 1'b0; clear_flag_b = 1'b0;
    if (!sel) begin
      reset_a = rst; enable_a = en; up_down_a = ud; load_a = ld;
      load_value_a = lv[3:0]; sat_mode_a = sat; clear_flag_a = clr;
    end else begin
      reset_b = rst; enable_b = en; up_down_b = ud; load_b = ld;
      load_value_b = lv[5:0]; sat_mode_b = sat; clear_flag_b = clr;
    end
    e.sel = sel; e.out = e_out; e.term = e_term; e.ovf = e_ovf; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [15:0] a_out;
    logic        a_term, a_ovf;
    a_out  = e.sel ? {10'd0, out_b} : {12'd0, out_a};
    a_term = e.sel ? terminal_b : terminal_a;
    a_ovf  = e.sel ? overflow_b : overflow_a;
    assertions++;
    if (a_out !== e.out || a_term !== e.term || a_ovf !== e.ovf) begin
      failures++;
      $display("[TB] FAIL %s: got out=%0d terminal=%0b overflow=%0b, expected out=%0d terminal=%0b overflow=%0b",
               e.name, a_out, a_term, a_ovf, e.out, e.term, e.ovf);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled just after the edge that produced it
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    // Instance A, up/wrap count through the MAX=9 bound
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "a_reset");
    for (int i = 1; i <= 12; i++) begin
      if (i <= 9)       applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 16'(i), 0, 0, "a_up");
      else if (i == 10) applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, "a_wrap9to0");
      else              applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 16'(i-10), 0, 1, "a_after_wrap");
    end

    // Down/saturate held at zero, then clear_flag alone
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "a_reset2");
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, "a_down_sat1");
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, "a_down_sat2");
    applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, "a_down_sat3");
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "a_clear");

    // Loads: clamp to MAX, load beats a step at the bound
    applyStimulus(0, 1, 0, 1, 1, 12, 0, 0, 9, 0, 0, "a_load_clamp");
    applyStimulus(0, 1, 1, 1, 1, 3, 0, 0, 3, 0, 0, "a_load_wins");
    applyStimulus(0, 1, 0, 1, 1, 9, 0, 0, 9, 0, 0, "a_load9");
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 1, "a_set_beats_clear");

    // Saturate at MAX, then switch to wrap; direction flip mid-range
    applyStimulus(0, 1, 0, 1, 1, 9, 1, 0, 9, 0, 1, "a_load9_b");
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 9, 1, 1, "a_sat_max1");
    applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 9, 1, 1, "a_sat_max2");
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, "a_mode_to_wrap");
    applyStimulus(0, 1, 0, 1, 1, 5, 0, 0, 5, 0, 1, "a_load5");
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 6, 0, 1, "a_up_to6");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 1, "a_down_to5");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 4, 0, 1, "a_down_to4");

    // Instance B, prescale by 4 with an enable gap
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, "b_reset");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "b_pre1");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "b_pre2");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "b_pre3");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, "b_step1");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, "b_pre1_again");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, "b_frozen");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, "b_resume_pre2");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, "b_resume_pre3");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 2, 0, 0, "b_step2");

    // Wrap at 63, build pre=2, then reset with load and enable all high
    applyStimulus(1, 1, 0, 1, 1, 63, 0, 0, 63, 0, 0, "b_load63");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 63, 0, 0, "b_pre_at63");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, "b_wrap63");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "b_pre1_post");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "b_pre2_post");
    applyStimulus(1, 0, 1, 1, 1, 10, 0, 0, 0, 0, 0, "b_reset_priority");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "b_pre_cleared");
    applyStimulus(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, "b_step_after_reset");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/contador_universal.md
Name: contador_universal

Overview:
- Parametrised successor to the fixed-function up counter: one configurable counter replaces the separate 2/4/6-bit instances.
- Adds:
  - programmable modulo (MAX)
  - enable prescaler
  - up/down direction
  - synchronous parallel load
  - wrap or saturate mode
  - registered terminal-count pulse
  - sticky overflow flag
- Used as the general event/timebase counter feeding display and control logic.

Parameters:
- WIDTH, 6, counter width in bits; legal range 1..16.
- MAX, (2**WIDTH)-1, highest count value; legal range 1..(2**WIDTH)-1.
- PRESCALE, 1, number of enabled cycles per count step; legal range 1..256.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- enable  input  1  qualifies prescaler advance; low freezes the prescaler and the count.
- up_down  input  1  1 = count up, 0 = count down; sampled at each step.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load; clamped to MAX.
- sat_mode  input  1  0 = wrap at bounds, 1 = saturate at bounds.
- clear_flag  input  1  clears the overflow flag.
- out  output  WIDTH  current count, registered.
- terminal  output  1  one-cycle registered pulse when a step hits a bound.
- overflow  output  1  sticky flag, set by any bound event.

Behaviour:
- Reset (reset==0 at a rising edge):
  - out=0, terminal=0, overflow=0, prescaler count pre=0.
  - Reset has priority over every other input, including mid-prescale and mid-load.
- Priority when reset==1: load > count step > hold.
- Load:
  - out <= (load_value > MAX) ? MAX : load_value; pre <= 0; terminal <= 0.
  - overflow is unchanged, apart from the effect of clear_flag.
  - Load is honoured regardless of enable.
- Prescaler:
  - When enable==1 and load==0: if pre==PRESCALE-1 then pre <= 0 and a step occurs; else pre <= pre+1.
  - When enable==0: pre and out hold.
  - With PRESCALE=1 a step occurs on every enabled cycle.
- Step, up (up_down==1):
  - out<MAX: out <= out+1, terminal <= 0.
  - out==MAX and sat_mode==0: out <= 0, terminal <= 1, overflow <= 1.
  - out==MAX and sat_mode==1: out holds MAX, terminal <= 1, overflow <= 1.
- Step, down (up_down==0):
  - out>0: out <= out-1, terminal <= 0.
  - out==0 and sat_mode==0: out <= MAX, terminal <= 1, overflow <= 1.
  - out==0 and sat_mode==1: out holds 0, terminal <= 1, overflow <= 1.
- terminal:
  - Asserted only in the cycle following a bound-event edge; 0 on every non-step cycle.
  - In saturate mode, pulses again on each further step attempted at the bound.
- Latency: out and terminal both update on the same edge that qualifies the step; zero additional pipeline.
- overflow:
  - Set by any bound event; cleared by clear_flag==1.
  - A bound event on the same edge as clear_flag leaves overflow=1 (set wins).
- up_down and sat_mode may change at any cycle. They take effect on the next step only; there is no retroactive effect on pre.
- Arithmetic is unsigned WIDTH-bit. out never exceeds MAX under any input sequence.
- Reset/load mid-prescale discards the partial prescale count.

Test Plan:
1. WIDTH=4, MAX=9, PRESCALE=1, up, wrap: release reset, enable=1 for 12 cycles -> out 1..9,0,1,2; terminal high exactly one cycle after out goes 9->0; overflow=1 from then on.
2. Same config, down, sat_mode=1, starting from out=0: 3 enabled cycles -> out stays 0; terminal pulses each cycle; overflow=1. Then clear_flag=1 alone -> overflow=0.
3. WIDTH=6, MAX=63, PRESCALE=4, up: enable=1 for 10 cycles -> out increments after cycles 4 and 8 (out=2). Drop enable for 3 cycles at cycle 6 -> out and pre frozen; the step resumes after the 4th enabled cycle.
4. Load: load=1, load_value=12 with MAX=9 -> out=9 next cycle, pre=0. load=1 with enable=1, up, at out=9 -> load wins, no terminal pulse.
5. Simultaneous events: a bound event on the same edge as clear_flag=1 -> overflow=1. reset=0 asserted mid-prescale (pre=2), with load=1 and enable=1 -> out=0, terminal=0, overflow=0, pre=0.
6. Mode change at the bound: out=MAX with sat_mode=1 held for 2 steps (out=MAX), then sat_mode=0 -> next step out=0, terminal=1. Direction flip at out=5 -> out 6 then 5, 4.
